// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the MEM stage of the pipelined ARMv8 core
//   (LDUR/STUR). One 64-bit request is in flight at a time; its one-cycle
//   response appears LATENCY cycles after the accept edge. The core is held
//   with stall while the request is outstanding.
//
// Parameters
//   DEPTH    number of 64-bit words in the array (power of 2, >= 2)
//   LATENCY  cycles from accept edge to resp_valid (>= 1)
//
// Build option
//   DMEM_ALIGN_CHECK_EN  when defined, misaligned or out-of-range addresses
//                        complete with resp_err=1; a rejected store does not
//                        write and a rejected load returns 0. When undefined,
//                        resp_err is 0 and addresses wrap modulo DEPTH*8.
//
// Ports
//   clk         in   rising-edge clock
//   Reset       in   synchronous, active-high reset (array contents kept)
//   req_valid   in   MEM stage presents a request
//   req_write   in   1 = store, 0 = load
//   req_addr    in   64-bit byte address (word index = addr[3+IW-1:3])
//   req_wdata   in   store data
//   req_ready   out  responder can accept this cycle
//   resp_valid  out  one-cycle completion pulse
//   resp_rdata  out  load data with resp_valid, 0 otherwise and for stores
//   resp_err    out  request rejected, qualified by resp_valid
//   stall       out  freeze IF..MEM pipeline registers
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// The responder samples the request fields only on that edge; while BUSY the
// request inputs are ignored and may change freely.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // state is the FSM's observable state for checkers bound to this block
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;

    logic          write_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rdata_q;
    logic [63:0]   mem [DEPTH];

    logic          accept;
    logic          commit;
    logic          c_write;
    logic [63:0]   c_addr;
    logic [63:0]   c_wdata;
    logic [IW-1:0] c_idx;
    logic          c_err;

    // Derived from state only so accept never loops back through req_ready
    assign accept = req_valid && (state != BUSY);

    // With LATENCY==1 the commit happens on the accept edge itself, so the
    // request is taken straight from the inputs; otherwise from the latch.
    assign c_write = (LATENCY == 1) ? req_write : write_q;
    assign c_addr  = (LATENCY == 1) ? req_addr  : addr_q;
    assign c_wdata = (LATENCY == 1) ? req_wdata : wdata_q;
    assign c_idx   = c_addr[3+IW-1:3];

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q;

    assign c_err    = (c_addr[2:0] != 3'b000) || (c_addr >= (64'(DEPTH) * 64'd8));
    assign resp_err = (state == RESP) && err_q;
`else
    // Byte-offset bits and bits above the index do not select anything
    logic unused_addr_bits;

    assign unused_addr_bits = ^{c_addr[63:3+IW], c_addr[2:0]};
    assign c_err            = 1'b0;
    assign resp_err         = 1'b0;
`endif

    always_comb begin
        state_next = state;
        req_ready  = 1'b1;
        stall      = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = (LATENCY == 1) ? RESP : BUSY;
            end
            BUSY: begin
                req_ready = 1'b0;
                stall     = 1'b1;
                if (cnt == CW'(1)) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (accept) state_next = (LATENCY == 1) ? RESP : BUSY;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Every entry into RESP (including RESP->RESP back-to-back) is a commit
    assign commit = (state_next == RESP);

    assign resp_rdata = resp_valid ? rdata_q : 64'd0;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == BUSY) begin
                cnt <= cnt - CW'(1);
            end
            if (commit) begin
                rdata_q <= (c_write || c_err) ? 64'd0 : mem[c_idx];
`ifdef DMEM_ALIGN_CHECK_EN
                err_q   <= c_err;
`endif
            end
        end
    end

    // Array is intentionally not reset; Reset only suppresses the write
    always_ff @(posedge clk) begin
        if (!Reset && commit && c_write && !c_err) begin
            mem[c_idx] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. Two instances: u_dut2 (LATENCY=2) and
//   u_dut1 (LATENCY=1), both DEPTH=256. Expected {resp_err, resp_rdata} words
//   are queued when a request is driven and popped by a negedge monitor when
//   the matching resp_valid pulse appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int W     = 65;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst2, rst1;

    // ---------------- DUT signals ----------------
    logic        v2 = 1'b0, w2 = 1'b0;
    logic [63:0] a2 = '0, wd2 = '0;
    logic        ready2, resp_valid2, resp_err2, stall2;
    logic [63:0] resp_rdata2;

    logic        v1 = 1'b0, w1 = 1'b0;
    logic [63:0] a1 = '0, wd1 = '0;
    logic        ready1, resp_valid1, resp_err1, stall1;
    logic [63:0] resp_rdata1;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
        .clk(clk), .Reset(rst2), .req_valid(v2), .req_write(w2), .req_addr(a2),
        .req_wdata(wd2), .req_ready(ready2), .resp_valid(resp_valid2),
        .resp_rdata(resp_rdata2), .resp_err(resp_err2), .stall(stall2));

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .Reset(rst1), .req_valid(v1), .req_write(w1), .req_addr(a1),
        .req_wdata(wd1), .req_ready(ready1), .resp_valid(resp_valid1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1), .stall(stall1));

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp1_q[$];
    int n_cmp = 0;
    int n_mis = 0;
    int n_resp2 = 0, n_resp1 = 0;
    int n_stall2 = 0, n_stall1 = 0;
    int resp_cyc2 = 0, acc_cyc2 = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (stall2 === 1'b1) n_stall2++;
        if (resp_valid2 === 1'b1) begin
            n_resp2++;
            resp_cyc2 = cyc;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_mis++;
                $error("FAIL resp2_unexpected: observed %h expected none", {resp_err2, resp_rdata2});
            end
            if (exp_q.size() > 0) check("resp2_data", {resp_err2, resp_rdata2}, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (stall1 === 1'b1) n_stall1++;
        if (resp_valid1 === 1'b1) begin
            n_resp1++;
            n_cmp++;
            assert (exp1_q.size() > 0) else begin
                n_mis++;
                $error("FAIL resp1_unexpected: observed %h expected none", {resp_err1, resp_rdata1});
            end
            if (exp1_q.size() > 0) check("resp1_data", {resp_err1, resp_rdata1}, exp1_q.pop_front());
        end
    end

    // ---------------- driver tasks (LATENCY=2 instance) ----------------
    task automatic wait_ready2();
        int i;
        i = 0;
        @(negedge clk);
        while (ready2 !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("ready2_timeout", {64'd0, ready2}, 65'd1);
    endtask

    task automatic req2(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                        input logic [W-1:0] exp);
        wait_ready2();
        w2 = wr; a2 = addr; wd2 = data; v2 = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        acc_cyc2 = cyc;
        v2 = 1'b0;
    endtask

    task automatic wait_resp2(input int target);
        int i;
        i = 0;
        while (n_resp2 < target && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("resp2_count", 65'(n_resp2), 65'(target));
    endtask

    // ---------------- stimulus ----------------
    logic [63:0] t3_addr [4];
    logic [63:0] t3_data [4];
    logic        t3_wr   [4];
    int          s_before;
    int          r_before;

    initial begin
        t3_addr = '{64'h40, 64'h40, 64'h48, 64'h48};
        t3_data = '{64'h1111_2222_3333_4444, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0};
        t3_wr   = '{1'b1, 1'b0, 1'b1, 1'b0};

        // 1: reset held two cycles
        rst2 = 1'b1; rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check("rst2_outputs", {61'd0, ready2, stall2, resp_valid2, resp_err2}, 65'b1000);
        check("rst2_rdata", {1'b0, resp_rdata2}, 65'd0);
        check("rst1_outputs", {61'd0, ready1, stall1, resp_valid1, resp_err1}, 65'b1000);
        check("rst1_rdata", {1'b0, resp_rdata1}, 65'd0);

        // 2: store then load, one stall cycle each, load latency 2
        s_before = n_stall2;
        req2(1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 65'd0);
        wait_resp2(1);
        check("store_stall_cycles", 65'(n_stall2 - s_before), 65'd1);
        s_before = n_stall2;
        req2(1'b0, 64'h10, 64'h0, {1'b0, 64'hDEAD_BEEF_CAFE_F00D});
        wait_resp2(2);
        check("load_stall_cycles", 65'(n_stall2 - s_before), 65'd1);
        check("load_latency", 65'(resp_cyc2 - acc_cyc2 + 1), 65'd2);
        @(negedge clk);
        check("post_resp_quiet", {resp_valid2, resp_rdata2}, 65'd0);

        // back-to-back store/load to same word; inputs change while BUSY
        wait_ready2();
        w2 = 1'b1; a2 = 64'h18; wd2 = 64'h0123_4567_89AB_CDEF; v2 = 1'b1;
        exp_q.push_back(65'd0);
        @(posedge clk);
        #1;
        w2 = 1'b0; a2 = 64'h18; wd2 = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_q.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
        wait_ready2();
        @(posedge clk);
        #1 v2 = 1'b0;
        wait_resp2(4);

        // 3: LATENCY=1 streaming, four requests with req_valid held high
        s_before = n_stall1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) check("l1_resp_every_cycle", {64'd0, resp_valid1}, 65'd1);
            v1 = 1'b1; w1 = t3_wr[i]; a1 = t3_addr[i]; wd1 = t3_data[i];
            exp1_q.push_back(t3_wr[i] ? 65'd0 : {1'b0, t3_data[i-1]});
        end
        @(negedge clk);
        check("l1_resp_last", {64'd0, resp_valid1}, 65'd1);
        v1 = 1'b0;
        @(negedge clk);
        check("l1_idle_after", {64'd0, resp_valid1}, 65'd0);
        check("l1_resp_total", 65'(n_resp1), 65'd4);
        check("l1_no_stall", 65'(n_stall1 - s_before), 65'd0);

        // 4: reset while BUSY on a store drops it
        req2(1'b1, 64'h20, 64'h1, 65'd0);
        wait_resp2(5);
        wait_ready2();
        w2 = 1'b1; a2 = 64'h20; wd2 = 64'hBAD0_BAD0_BAD0_BAD0; v2 = 1'b1;
        @(posedge clk);
        #1 v2 = 1'b0; rst2 = 1'b1;
        @(posedge clk);
        #1 rst2 = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {61'd0, ready2, stall2, resp_valid2, resp_err2}, 65'b1000);
        r_before = n_resp2;
        repeat (3) @(negedge clk);
        check("midrst_no_resp", 65'(n_resp2 - r_before), 65'd0);

        // reset together with an accept: nothing latched
        w2 = 1'b1; a2 = 64'h20; wd2 = 64'hBAD1_BAD1_BAD1_BAD1; v2 = 1'b1; rst2 = 1'b1;
        @(posedge clk);
        #1 rst2 = 1'b0; v2 = 1'b0;
        @(negedge clk);
        check("rst_accept_idle", {63'd0, ready2, stall2}, 65'b10);
        repeat (3) @(negedge clk);
        check("rst_accept_no_resp", 65'(n_resp2 - r_before), 65'd0);
        req2(1'b0, 64'h20, 64'h0, {1'b0, 64'h1});
        wait_resp2(6);

`ifdef DMEM_ALIGN_CHECK_EN
        // 5: misaligned store and out-of-range load are rejected
        req2(1'b1, 64'h10, 64'h7777_0000_7777_0000, 65'd0);
        wait_resp2(7);
        req2(1'b1, 64'h13, 64'h9999_9999_9999_9999, {1'b1, 64'h0});
        wait_resp2(8);
        req2(1'b0, 64'(DEPTH * 8), 64'h0, {1'b1, 64'h0});
        wait_resp2(9);
        req2(1'b0, 64'h10, 64'h0, {1'b0, 64'h7777_0000_7777_0000});
        wait_resp2(10);
`else
        // 6: addresses wrap modulo DEPTH*8 and ignore the byte offset
        req2(1'b1, 64'h800, 64'h5, 65'd0);
        wait_resp2(7);
        req2(1'b0, 64'h0, 64'h0, {1'b0, 64'h5});
        wait_resp2(8);
        req2(1'b1, 64'h13, 64'h9, 65'd0);
        wait_resp2(9);
        req2(1'b0, 64'h10, 64'h0, {1'b0, 64'h9});
        wait_resp2(10);
        check("err_const_zero", {64'd0, resp_err2}, 65'd0);
`endif

        repeat (2) @(negedge clk);
        check("queue2_drained", 65'(exp_q.size()), 65'd0);
        check("queue1_drained", 65'(exp1_q.size()), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end of run expected finish before 200000ns");
        $fatal(1, "timeout");
    end

endmodule
